// File: rtl/msg_schedule_gen.sv
// msg_schedule_gen: SHA-2 message-schedule generator.
//
// Accepts one 16-word padded block over a valid/ready handshake. It then
// streams W_0..W_{ROUNDS-1} to the compression core, one word per accepted
// output handshake. A 16-entry sliding window holds the words, and win[0] is
// the word currently presented on the output.
//
// Parameters:
//   WORD_W  word width: 32 selects SHA-256 sigmas, 64 selects SHA-512 sigmas
//   ROUNDS  schedule length: 64 for SHA-256, 80 for SHA-512
//   IDX_W   width of the round index; 2**IDX_W must be >= ROUNDS
//
// Ports:
//   clk        clock
//   reset_n    asynchronous active-low reset
//   abort      synchronous flush back to IDLE; has priority over load/shift
//   blk_valid  a block is present on 'block'
//   blk_ready  a block is accepted when blk_valid && blk_ready
//              (combinational from w_ready and abort)
//   block      16*WORD_W padded block, word 0 in the MSBs
//   w_valid    schedule word valid
//   w_ready    consumer accepts the current word
//   w_data     current W_t
//   w_idx      current t
//   w_last     high when t == ROUNDS-1
//   blk_cnt    [only with MSG_SCHED_CNT_EN] count of fully streamed blocks
//
// Optional build macro: MSG_SCHED_CNT_EN adds the blk_cnt output and the
// counter that drives it.

`timescale 1ns/1ps

module msg_schedule_gen #(
  parameter int unsigned WORD_W = 32,
  parameter int unsigned ROUNDS = 64,
  parameter int unsigned IDX_W  = 7
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  abort,
  input  logic                  blk_valid,
  output logic                  blk_ready,
  input  logic [16*WORD_W-1:0]  block,
  output logic                  w_valid,
  input  logic                  w_ready,
  output logic [WORD_W-1:0]     w_data,
  output logic [IDX_W-1:0]      w_idx,
  output logic                  w_last
`ifdef MSG_SCHED_CNT_EN
  ,
  output logic [31:0]           blk_cnt
`endif
);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

  state_e              state_q, state_d;
  logic [WORD_W-1:0]   win_q [16];
  logic [WORD_W-1:0]   win_d [16];
  logic [IDX_W-1:0]    idx_q, idx_d;

  logic                is_run;
  logic                last;
  logic                fire;
  logic                final_hs;
  logic                load;
  logic [WORD_W-1:0]   new_word;

  function automatic logic [WORD_W-1:0] rotr(input logic [WORD_W-1:0] x,
                                             input int unsigned       n);
    return (x >> n) | (x << (WORD_W - n));
  endfunction

  function automatic logic [WORD_W-1:0] sigma0(input logic [WORD_W-1:0] x);
    if (WORD_W == 64) return rotr(x, 1) ^ rotr(x, 8) ^ (x >> 7);
    else              return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
  endfunction

  function automatic logic [WORD_W-1:0] sigma1(input logic [WORD_W-1:0] x);
    if (WORD_W == 64) return rotr(x, 19) ^ rotr(x, 61) ^ (x >> 6);
    else              return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
  endfunction

  assign is_run   = (state_q == RUN);
  assign last     = is_run && (idx_q == IDX_W'(ROUNDS - 1));
  assign fire     = is_run && w_ready;
  assign final_hs = last && w_ready;

  // A block can be taken while idle, or in the same cycle as the final
  // handshake; that gives zero-bubble back-to-back blocks.
  assign blk_ready = !abort && (!is_run || final_hs);
  assign load      = blk_valid && blk_ready;

  // When win[0] holds W[t], the word that enters win[15] is W[t+16]:
  // W[t+16] = s1(W[t+14]) + W[t+9] + s0(W[t+1]) + W[t]
  assign new_word = sigma1(win_q[14]) + win_q[9] + sigma0(win_q[1]) + win_q[0];

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    win_d   = win_q;
    if (abort) begin
      // The window is deliberately left intact; only control state is flushed.
      state_d = IDLE;
      idx_d   = '0;
    end else if (load) begin
      for (int unsigned i = 0; i < 16; i++) begin
        win_d[i] = block[(16 - i) * WORD_W - 1 -: WORD_W];
      end
      idx_d   = '0;
      state_d = RUN;
    end else if (fire) begin
      for (int unsigned i = 0; i < 15; i++) begin
        win_d[i] = win_q[i + 1];
      end
      win_d[15] = new_word;
      idx_d     = idx_q + IDX_W'(1);
      if (last) state_d = IDLE;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      idx_q   <= '0;
      for (int unsigned i = 0; i < 16; i++) begin
        win_q[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      win_q   <= win_d;
    end
  end

  assign w_valid = is_run;
  assign w_data  = win_q[0];
  assign w_idx   = idx_q;
  assign w_last  = last;

`ifdef MSG_SCHED_CNT_EN
  logic [31:0] blk_cnt_q, blk_cnt_d;

  always_comb begin
    blk_cnt_d = blk_cnt_q;
    if (w_last && w_valid && w_ready) blk_cnt_d = blk_cnt_q + 32'd1;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) blk_cnt_q <= '0;
    else          blk_cnt_q <= blk_cnt_d;
  end

  assign blk_cnt = blk_cnt_q;
`endif

endmodule

// File: tb/tb_msg_schedule_gen.sv
`timescale 1ns/1ps

module tb_msg_schedule_gen;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset_n;
  logic          ab32, bv32, br32, wv32, wr32, wl32;
  logic [511:0]  blk32;
  logic [31:0]   wd32;
  logic [6:0]    wi32;
  logic          ab64, bv64, br64, wv64, wr64, wl64;
  logic [1023:0] blk64;
  logic [63:0]   wd64;
  logic [6:0]    wi64;
`ifdef MSG_SCHED_CNT_EN
  logic [31:0]   cnt32, cnt64;
`endif

  int checks = 0;
  int passes = 0;
  int exp_cnt32 = 0;
  int exp_cnt64 = 0;

  msg_schedule_gen #(.WORD_W(32), .ROUNDS(64), .IDX_W(7)) d32 (
    .clk(clk), .reset_n(reset_n), .abort(ab32),
    .blk_valid(bv32), .blk_ready(br32), .block(blk32),
    .w_valid(wv32), .w_ready(wr32), .w_data(wd32), .w_idx(wi32), .w_last(wl32)
`ifdef MSG_SCHED_CNT_EN
    , .blk_cnt(cnt32)
`endif
  );

  msg_schedule_gen #(.WORD_W(64), .ROUNDS(80), .IDX_W(7)) d64 (
    .clk(clk), .reset_n(reset_n), .abort(ab64),
    .blk_valid(bv64), .blk_ready(br64), .block(blk64),
    .w_valid(wv64), .w_ready(wr64), .w_data(wd64), .w_idx(wi64), .w_last(wl64)
`ifdef MSG_SCHED_CNT_EN
    , .blk_cnt(cnt64)
`endif
  );

  localparam logic [511:0]  ABC32 = {32'h61626380, {14{32'h0}}, 32'h00000018};
  localparam logic [1023:0] ABC64 = {64'h6162638000000000, {14{64'h0}}, 64'h18};

  logic [511:0]       blkb32;
  logic [63:0][31:0]  refA32, refB32;
  logic [79:0][63:0]  refA64;

  // Reference schedule over a full W[] array, independent of any window.
  function automatic logic [31:0] s0_32(input logic [31:0] x);
    return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ {3'b0, x[31:3]};
  endfunction
  function automatic logic [31:0] s1_32(input logic [31:0] x);
    return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ {10'b0, x[31:10]};
  endfunction
  function automatic logic [63:0] s0_64(input logic [63:0] x);
    return {x[0], x[63:1]} ^ {x[7:0], x[63:8]} ^ {7'b0, x[63:7]};
  endfunction
  function automatic logic [63:0] s1_64(input logic [63:0] x);
    return {x[18:0], x[63:19]} ^ {x[60:0], x[63:61]} ^ {6'b0, x[63:6]};
  endfunction

  function automatic logic [63:0][31:0] sched32(input logic [511:0] b);
    logic [63:0][31:0] w;
    for (int t = 0; t < 16; t++) w[t] = b[(15 - t) * 32 +: 32];
    for (int t = 16; t < 64; t++)
      w[t] = s1_32(w[t-2]) + w[t-7] + s0_32(w[t-15]) + w[t-16];
    return w;
  endfunction

  function automatic logic [79:0][63:0] sched64(input logic [1023:0] b);
    logic [79:0][63:0] w;
    for (int t = 0; t < 16; t++) w[t] = b[(15 - t) * 64 +: 64];
    for (int t = 16; t < 80; t++)
      w[t] = s1_64(w[t-2]) + w[t-7] + s0_64(w[t-15]) + w[t-16];
    return w;
  endfunction

  task automatic test_reset;
    reset_n = 1'b0;
    ab32 = 0; bv32 = 0; wr32 = 0; blk32 = '0;
    ab64 = 0; bv64 = 0; wr64 = 0; blk64 = '0;
    repeat (2) @(negedge clk);
    #1;
    checks++; if (wv32 !== 1'b0) $display("FAIL rst_wvalid: got %b exp 0", wv32); else passes++;
    checks++; if (wl32 !== 1'b0) $display("FAIL rst_wlast: got %b exp 0", wl32); else passes++;
    checks++; if (wd32 !== 32'h0) $display("FAIL rst_wdata: got %h exp 0", wd32); else passes++;
    checks++; if (wi32 !== 7'd0) $display("FAIL rst_widx: got %0d exp 0", wi32); else passes++;
    checks++; if (wv64 !== 1'b0) $display("FAIL rst_wvalid64: got %b exp 0", wv64); else passes++;
    reset_n = 1'b1;
    @(negedge clk); #1;
    checks++; if (br32 !== 1'b1) $display("FAIL rst_blkready: got %b exp 1", br32); else passes++;
    checks++; if (br64 !== 1'b1) $display("FAIL rst_blkready64: got %b exp 1", br64); else passes++;
  endtask

  task automatic test_abc32;
    bv32 = 1; blk32 = ABC32; wr32 = 1; #1;
    checks++; if (br32 !== 1'b1) $display("FAIL abc32_accept: got %b exp 1", br32); else passes++;
    for (int t = 0; t < 64; t++) begin
      @(negedge clk); #1;
      if (t == 0) begin bv32 = 0; blk32 = '0; end
      checks++; if (wv32 !== 1'b1) $display("FAIL abc32_valid t=%0d: got %b exp 1", t, wv32); else passes++;
      checks++; if (wi32 !== 7'(t)) $display("FAIL abc32_idx t=%0d: got %0d", t, wi32); else passes++;
      checks++; if (wd32 !== refA32[t]) $display("FAIL abc32_data t=%0d: got %h exp %h", t, wd32, refA32[t]); else passes++;
      checks++; if (wl32 !== (t == 63)) $display("FAIL abc32_last t=%0d: got %b", t, wl32); else passes++;
      if (t == 0) begin
        checks++; if (wd32 !== 32'h61626380) $display("FAIL abc32_W0: got %h exp 61626380", wd32); else passes++;
      end
      if (t == 15) begin
        checks++; if (wd32 !== 32'h00000018) $display("FAIL abc32_W15: got %h exp 00000018", wd32); else passes++;
      end
      if (t == 16) begin
        checks++; if (wd32 !== 32'h61626380) $display("FAIL abc32_W16: got %h exp 61626380", wd32); else passes++;
      end
      if (t == 17) begin
        checks++; if (wd32 !== 32'h000F0000) $display("FAIL abc32_W17: got %h exp 000f0000", wd32); else passes++;
      end
    end
    exp_cnt32++;
    @(negedge clk); #1;
    checks++; if (wv32 !== 1'b0) $display("FAIL abc32_done_valid: got %b exp 0", wv32); else passes++;
    checks++; if (br32 !== 1'b1) $display("FAIL abc32_done_ready: got %b exp 1", br32); else passes++;
`ifdef MSG_SCHED_CNT_EN
    checks++; if (cnt32 !== 32'(exp_cnt32)) $display("FAIL abc32_cnt: got %0d exp %0d", cnt32, exp_cnt32); else passes++;
`endif
  endtask

  task automatic test_abc64;
    bv64 = 1; blk64 = ABC64; wr64 = 1; #1;
    checks++; if (br64 !== 1'b1) $display("FAIL abc64_accept: got %b exp 1", br64); else passes++;
    for (int t = 0; t < 80; t++) begin
      @(negedge clk); #1;
      if (t == 0) begin bv64 = 0; blk64 = '0; end
      checks++; if (wv64 !== 1'b1) $display("FAIL abc64_valid t=%0d: got %b exp 1", t, wv64); else passes++;
      checks++; if (wi64 !== 7'(t)) $display("FAIL abc64_idx t=%0d: got %0d", t, wi64); else passes++;
      checks++; if (wd64 !== refA64[t]) $display("FAIL abc64_data t=%0d: got %h exp %h", t, wd64, refA64[t]); else passes++;
      checks++; if (wl64 !== (t == 79)) $display("FAIL abc64_last t=%0d: got %b", t, wl64); else passes++;
      if (t == 16) begin
        checks++; if (wd64 !== 64'h6162638000000000) $display("FAIL abc64_W16: got %h exp 6162638000000000", wd64); else passes++;
      end
      if (t == 17) begin
        checks++; if (wd64 !== 64'h00030000000000C0) $display("FAIL abc64_W17: got %h exp 00030000000000c0", wd64); else passes++;
      end
    end
    exp_cnt64++;
    @(negedge clk); #1;
    checks++; if (wv64 !== 1'b0) $display("FAIL abc64_done_valid: got %b exp 0", wv64); else passes++;
    checks++; if (br64 !== 1'b1) $display("FAIL abc64_done_ready: got %b exp 1", br64); else passes++;
`ifdef MSG_SCHED_CNT_EN
    checks++; if (cnt64 !== 32'(exp_cnt64)) $display("FAIL abc64_cnt: got %0d exp %0d", cnt64, exp_cnt64); else passes++;
`endif
  endtask

  task automatic test_stall;
    bv32 = 1; blk32 = ABC32; wr32 = 1; #1;
    for (int t = 0; t < 64; t++) begin
      @(negedge clk); #1;
      if (t == 0) begin bv32 = 0; blk32 = '0; end
      checks++; if (wi32 !== 7'(t)) $display("FAIL stall_idx t=%0d: got %0d", t, wi32); else passes++;
      checks++; if (wd32 !== refA32[t]) $display("FAIL stall_data t=%0d: got %h exp %h", t, wd32, refA32[t]); else passes++;
      if (t == 20) begin
        wr32 = 0;
        for (int k = 0; k < 5; k++) begin
          @(negedge clk); #1;
          checks++; if (wv32 !== 1'b1) $display("FAIL stall_hold_valid k=%0d: got %b exp 1", k, wv32); else passes++;
          checks++; if (wi32 !== 7'd20) $display("FAIL stall_hold_idx k=%0d: got %0d exp 20", k, wi32); else passes++;
          checks++; if (wd32 !== refA32[20]) $display("FAIL stall_hold_data k=%0d: got %h exp %h", k, wd32, refA32[20]); else passes++;
          checks++; if (wl32 !== 1'b0) $display("FAIL stall_hold_last k=%0d: got %b exp 0", k, wl32); else passes++;
        end
        wr32 = 1;
      end
    end
    exp_cnt32++;
    @(negedge clk); #1;
    checks++; if (wv32 !== 1'b0) $display("FAIL stall_done_valid: got %b exp 0", wv32); else passes++;
  endtask

  task automatic test_back_to_back;
    bv32 = 1; blk32 = ABC32; wr32 = 1; #1;
    for (int t = 0; t < 64; t++) begin
      @(negedge clk); #1;
      if (t == 0) blk32 = blkb32;
      checks++; if (wd32 !== refA32[t]) $display("FAIL b2b_A_data t=%0d: got %h exp %h", t, wd32, refA32[t]); else passes++;
      checks++; if (br32 !== (t == 63)) $display("FAIL b2b_ready t=%0d: got %b", t, br32); else passes++;
    end
    exp_cnt32++;
    for (int t = 0; t < 64; t++) begin
      @(negedge clk); #1;
      if (t == 0) begin
        checks++; if (wv32 !== 1'b1) $display("FAIL b2b_nobubble_valid: got %b exp 1", wv32); else passes++;
        checks++; if (wi32 !== 7'd0) $display("FAIL b2b_B_idx0: got %0d exp 0", wi32); else passes++;
        checks++; if (wd32 !== 32'h11111111) $display("FAIL b2b_B_word0: got %h exp 11111111", wd32); else passes++;
        bv32 = 0; blk32 = '0;
      end
      checks++; if (wi32 !== 7'(t)) $display("FAIL b2b_B_idx t=%0d: got %0d", t, wi32); else passes++;
      checks++; if (wd32 !== refB32[t]) $display("FAIL b2b_B_data t=%0d: got %h exp %h", t, wd32, refB32[t]); else passes++;
    end
    exp_cnt32++;
    @(negedge clk); #1;
    checks++; if (wv32 !== 1'b0) $display("FAIL b2b_done_valid: got %b exp 0", wv32); else passes++;
`ifdef MSG_SCHED_CNT_EN
    checks++; if (cnt32 !== 32'(exp_cnt32)) $display("FAIL b2b_cnt: got %0d exp %0d", cnt32, exp_cnt32); else passes++;
`endif
  endtask

  task automatic test_abort;
    bv32 = 1; blk32 = ABC32; wr32 = 1; #1;
    for (int t = 0; t <= 30; t++) begin
      @(negedge clk); #1;
      if (t == 0) begin bv32 = 0; blk32 = '0; end
      checks++; if (wi32 !== 7'(t)) $display("FAIL abort_pre_idx t=%0d: got %0d", t, wi32); else passes++;
    end
    ab32 = 1; bv32 = 1; blk32 = blkb32; #1;
    checks++; if (br32 !== 1'b0) $display("FAIL abort_blkready: got %b exp 0", br32); else passes++;
    @(negedge clk); #1;
    ab32 = 0; bv32 = 0; #1;
    checks++; if (wv32 !== 1'b0) $display("FAIL abort_valid: got %b exp 0", wv32); else passes++;
    checks++; if (wi32 !== 7'd0) $display("FAIL abort_idx: got %0d exp 0", wi32); else passes++;
    checks++; if (br32 !== 1'b1) $display("FAIL abort_idle_ready: got %b exp 1", br32); else passes++;
`ifdef MSG_SCHED_CNT_EN
    checks++; if (cnt32 !== 32'(exp_cnt32)) $display("FAIL abort_cnt: got %0d exp %0d", cnt32, exp_cnt32); else passes++;
`endif
    bv32 = 1; #1;
    for (int t = 0; t < 64; t++) begin
      @(negedge clk); #1;
      if (t == 0) begin bv32 = 0; blk32 = '0; end
      checks++; if (wi32 !== 7'(t)) $display("FAIL abort_B_idx t=%0d: got %0d", t, wi32); else passes++;
      checks++; if (wd32 !== refB32[t]) $display("FAIL abort_B_data t=%0d: got %h exp %h", t, wd32, refB32[t]); else passes++;
    end
    exp_cnt32++;
    @(negedge clk); #1;
    checks++; if (wv32 !== 1'b0) $display("FAIL abort_done_valid: got %b exp 0", wv32); else passes++;
  endtask

  task automatic test_reset_mid;
    bv32 = 1; blk32 = ABC32; wr32 = 1; #1;
    for (int t = 0; t <= 10; t++) begin
      @(negedge clk); #1;
      if (t == 0) begin bv32 = 0; blk32 = '0; end
    end
    reset_n = 0; #1;
    checks++; if (wv32 !== 1'b0) $display("FAIL rmid_valid: got %b exp 0", wv32); else passes++;
    checks++; if (wd32 !== 32'h0) $display("FAIL rmid_data: got %h exp 0", wd32); else passes++;
    checks++; if (wi32 !== 7'd0) $display("FAIL rmid_idx: got %0d exp 0", wi32); else passes++;
    checks++; if (wl32 !== 1'b0) $display("FAIL rmid_last: got %b exp 0", wl32); else passes++;
    exp_cnt32 = 0; exp_cnt64 = 0;
    @(negedge clk); #1;
    reset_n = 1; #1;
    checks++; if (br32 !== 1'b1) $display("FAIL rmid_ready: got %b exp 1", br32); else passes++;
    checks++; if (wv32 !== 1'b0) $display("FAIL rmid_idle_valid: got %b exp 0", wv32); else passes++;
    bv32 = 1; blk32 = blkb32; #1;
    for (int t = 0; t < 64; t++) begin
      @(negedge clk); #1;
      if (t == 0) begin bv32 = 0; blk32 = '0; end
      checks++; if (wi32 !== 7'(t)) $display("FAIL rmid_B_idx t=%0d: got %0d", t, wi32); else passes++;
      checks++; if (wd32 !== refB32[t]) $display("FAIL rmid_B_data t=%0d: got %h exp %h", t, wd32, refB32[t]); else passes++;
    end
    exp_cnt32++;
    @(negedge clk); #1;
    checks++; if (wv32 !== 1'b0) $display("FAIL rmid_done_valid: got %b exp 0", wv32); else passes++;
`ifdef MSG_SCHED_CNT_EN
    checks++; if (cnt32 !== 32'(exp_cnt32)) $display("FAIL rmid_cnt: got %0d exp %0d", cnt32, exp_cnt32); else passes++;
    checks++; if (cnt64 !== 32'(exp_cnt64)) $display("FAIL rmid_cnt64: got %0d exp %0d", cnt64, exp_cnt64); else passes++;
`endif
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 16; i++) blkb32[(15 - i) * 32 +: 32] = 32'(32'h11111111 * (i + 1));
    refA32 = sched32(ABC32);
    refB32 = sched32(blkb32);
    refA64 = sched64(ABC64);
    test_reset;
    test_abc32;
    test_abc64;
    test_stall;
    test_back_to_back;
    test_abort;
    test_reset_mid;
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/msg_schedule_gen.md
Name: msg_schedule_gen

Overview:
Parametrised SHA-2 message-schedule generator for both SHA-256 (32-bit words, 64 rounds) and SHA-512 (64-bit words, 80 rounds).
- Accepts a 16-word padded block over a valid/ready handshake.
- Streams W_0..W_{ROUNDS-1} one word per accepted output handshake to the compression core, using a 16-entry sliding window.
- Supports back-pressure, abort and zero-bubble back-to-back blocks.

Parameters:
WORD_W, 32, word width. Legal values: 32 (SHA-256 sigmas) or 64 (SHA-512 sigmas).
ROUNDS, 64, schedule length. Use 64 with WORD_W=32 and 80 with WORD_W=64.
IDX_W, 7, width of the round index. Must satisfy 2^IDX_W >= ROUNDS.

Ports:
clk  in  1  clock
reset_n  in  1  asynchronous active-low reset
abort  in  1  synchronous flush to IDLE
blk_valid  in  1  block present
blk_ready  out  1  block accepted when blk_valid && blk_ready
block  in  16*WORD_W  padded block; word 0 in the MSBs
w_valid  out  1  schedule word valid
w_ready  in  1  consumer accepts word
w_data  out  WORD_W  current W_t
w_idx  out  IDX_W  current t
w_last  out  1  high when t == ROUNDS-1

Behaviour:
Reset and clocking:
- reset_n is asynchronous, active-low; clk is the clock.
- On reset: state=IDLE, window registers=0, idx=0, w_valid=0, w_last=0, w_data=0, w_idx=0.
- blk_ready goes to 1 immediately after reset (IDLE).
- Reset asserted mid-block discards all state; no further words are emitted.

Sigma functions:
- WORD_W=32: s0 = ROTR7^ROTR18^SHR3 of W[t-15]; s1 = ROTR17^ROTR19^SHR10 of W[t-2].
- WORD_W=64: s0 = ROTR1^ROTR8^SHR7; s1 = ROTR19^ROTR61^SHR6.
- New word = s1 + W[t-7] + s0 + W[t-16], computed modulo 2^WORD_W (carries discarded).

Window:
- win[0..15]; win[0] is the output.
- Load: win[i] = block[(16-i)*WORD_W-1 -: WORD_W].
- Shift: win[i] <= win[i+1]; win[15] <= new word, computed from win[0], win[1], win[9] and win[14].

State machine, IDLE / RUN:
- IDLE: w_valid=0. On blk_valid: load the window, idx=0, go to RUN.
- RUN: w_valid=1, w_data=win[0], w_idx=idx, w_last=(idx==ROUNDS-1).
- On w_ready in RUN: shift and idx++.
- On the final handshake (w_last && w_ready): go to IDLE, unless a block is loaded in the same cycle.
- Words for t>=16 are generated while shifting. Shifts past the end are don't-care and never observed.

Handshake rules:
- blk_ready = (state==IDLE) || (w_last && w_ready). This combinational path from w_ready is intentional.
- Load in the same cycle as the final handshake: the new block loads, idx=0, stay in RUN, and w_valid stays high with no bubble.
- Latency: block accept to first w_valid is 1 cycle.
- Stall (w_valid && !w_ready): w_data, w_idx, w_last and the window hold stable for any number of cycles.
- w_valid never drops in RUN before the final handshake.

Abort:
- abort=1 has priority over load and shift: next state IDLE, idx=0, w_valid=0; the window is not cleared.
- blk_ready is forced 0 in a cycle where abort=1, so no block is accepted.

Optional Feature:
MSG_SCHED_CNT_EN.
- Defined: adds output blk_cnt [31:0], reset to 0.
- blk_cnt increments by 1 on each final handshake (w_last && w_valid && w_ready) and wraps at 2^32.
- Not incremented by abort or by a block that was started but not finished.
- Undefined: no port, no counter logic.

Test Plan:
- WORD_W=32, "abc" padded block (word0=0x61626380, word15=0x00000018, others 0), w_ready=1 -> W0=0x61626380, W15=0x00000018, W16=0x61626380, W17=0x000F0000; exactly 64 words; w_last only at w_idx=63; blk_ready high the next cycle.
- WORD_W=64, ROUNDS=80, "abc" block (word0=0x6162638000000000, word15=0x18) -> W16=0x6162638000000000, W17=0x00030000000000C0; 80 words; w_last at w_idx=79.
- Stall: w_ready=0 for 5 cycles at w_idx=20 -> w_data/w_idx unchanged across all 5 cycles; resumes with w_idx=21 and the same sequence as the unstalled run.
- Back-to-back: blk_valid held high with block B queued during block A -> the cycle after A's w_idx=63 handshake shows w_valid=1, w_idx=0, w_data=B word0, with no idle cycle.
- Abort at w_idx=30 together with blk_valid=1 -> blk_ready=0 that cycle; next cycle IDLE, w_valid=0; the following block restarts at w_idx=0. With MSG_SCHED_CNT_EN, blk_cnt is unchanged by the abort.
- reset_n low mid-block (w_idx=10) -> outputs immediately 0 and state IDLE; after release blk_ready=1 and the next block streams correctly from w_idx=0.
